// File: rtl/scan_event_decoder.sv
// PS/2 set-2 prefix folder with event FIFO and ctrl/err strobes.
// Optional prefix timeout: define SCAN_PREFIX_TIMEOUT_EN.
module scan_event_decoder #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic [7:0]               word,
  input  logic                     done,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_rel,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic [7:0]               ctrl_byte,
  output logic                     ctrl_valid,
  output logic                     err_pulse,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     prefix_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    E0   = 2'd1,
    F0   = 2'd2,
    E0F0 = 2'd3
  } state_t;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  state_t          state_q, state_d;
  logic            done_q;
  logic            accept;
  logic            is_e0, is_f0, is_ctrl, is_err;
  logic            emit;
  evt_t            evt_d;
  logic            tmo_d;

  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  evt_t            mem_q [DEPTH];
  evt_t            head;
  logic            full, push, pop;

  logic            ovf_q, ovf_d;
  logic [7:0]      cbyte_q, cbyte_d;
  logic            cval_q, cval_d;
  logic            err_q, err_d;
  logic            tmo_q;

  assign accept  = done & ~done_q;
  assign is_e0   = (word == 8'hE0);
  assign is_f0   = (word == 8'hF0);
  assign is_err  = (word == 8'h00) || (word == 8'hFF);
  assign is_ctrl = (word == 8'hAA) || (word == 8'hFA) ||
                   (word == 8'hEE) || (word == 8'hFC) ||
                   (word == 8'hFE);

`ifdef SCAN_PREFIX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          expire;

  // Prefix age: restarts on every byte, runs only while a prefix waits.
  always_comb begin
    tcnt_d = '0;
    if (!accept && state_q != IDLE) tcnt_d = tcnt_q + 1'b1;
  end

  assign expire = !accept && state_q != IDLE &&
                  tcnt_q == TW'(TIMEOUT_CYCLES - 1);

  // Timeout counter register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end
`else
  logic expire;
  assign expire = 1'b0;
`endif

  // Next state and event build for the accepted byte.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    evt_d   = '{rel: 1'b0, ext: 1'b0, code: word};
    tmo_d   = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_ctrl || is_err: state_d = IDLE;
        is_e0: begin
          unique case (state_q)
            IDLE:    state_d = E0;
            E0:      state_d = E0;
            F0:      state_d = E0F0;
            default: state_d = E0F0;
          endcase
        end
        is_f0: begin
          unique case (state_q)
            IDLE:    state_d = F0;
            E0:      state_d = E0F0;
            F0:      state_d = F0;
            default: state_d = E0F0;
          endcase
        end
        default: begin
          emit      = 1'b1;
          evt_d.ext = (state_q == E0) || (state_q == E0F0);
          evt_d.rel = (state_q == F0) || (state_q == E0F0);
          state_d   = IDLE;
        end
      endcase
    end else if (expire) begin
      state_d = IDLE;
      tmo_d   = 1'b1;
    end
  end

  // FIFO pointer/count update; full+pop lets the write through.
  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    pop    = evt_valid && evt_ready;
    push   = emit && (!full || pop);
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
    ovf_d  = ovf_q;
    if (emit && full && !pop) ovf_d = 1'b1;
    if (ovf_clr)              ovf_d = 1'b0;
    cbyte_d = (accept && is_ctrl) ? word : cbyte_q;
    cval_d  = accept && is_ctrl;
    err_d   = accept && is_err;
  end

  // Control registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      cbyte_q <= '0;
      cval_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      cbyte_q <= cbyte_d;
      cval_q  <= cval_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Event storage; contents are don't-care until written.
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_q] <= evt_d;
  end

  assign head           = mem_q[rd_q];
  assign evt_valid      = (cnt_q != '0);
  assign evt_code       = evt_valid ? head.code : 8'h00;
  assign evt_ext        = evt_valid & head.ext;
  assign evt_rel        = evt_valid & head.rel;
  assign evt_count      = cnt_q;
  assign ctrl_byte      = cbyte_q;
  assign ctrl_valid     = cval_q;
  assign err_pulse      = err_q;
  assign overflow       = ovf_q;
  assign prefix_timeout = tmo_q;

endmodule

// File: tb/tb_scan_event_decoder.sv
// Scoreboard bench for scan_event_decoder.
// Expected events are queued on send and popped on output.
module tb_scan_event_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic       sysclk = 0;
  logic       rst_n  = 0;
  logic [7:0] word   = 0;
  logic       done   = 0;
  logic       evt_ready = 0;
  logic       ovf_clr   = 0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_rel, evt_valid;
  logic [$clog2(DEPTH):0] evt_count;
  logic [7:0] ctrl_byte;
  logic       ctrl_valid, err_pulse, overflow, prefix_timeout;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q [$];

  always #5 sysclk = ~sysclk;

  scan_event_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .word(word), .done(done),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_rel(evt_rel),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_count(evt_count), .ctrl_byte(ctrl_byte),
    .ctrl_valid(ctrl_valid), .err_pulse(err_pulse),
    .overflow(overflow), .ovf_clr(ovf_clr),
    .prefix_timeout(prefix_timeout)
  );

  // Called at a negedge; returns strobes seen one cycle after accept.
  task automatic send(input logic [7:0] b, input int hold,
                      output logic cv, output logic ep,
                      output logic ev);
    word = b;
    done = 1;
    @(negedge sysclk);
    cv = ctrl_valid;
    ep = err_pulse;
    ev = evt_valid;
    repeat (hold - 1) @(negedge sysclk);
    done = 0;
    @(negedge sysclk);
  endtask

  task automatic drain(input string nm);
    int g = 0;
    logic [9:0] e;
    evt_ready = 1;
    while ((evt_valid || exp_q.size() != 0) && g < 60) begin
      if (evt_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra event got %h", nm,
                   {evt_rel, evt_ext, evt_code});
        end else begin
          e = exp_q.pop_front();
          if ({evt_rel, evt_ext, evt_code} !== e) begin
            errors++;
            $display("FAIL %s event got %h want %h", nm,
                     {evt_rel, evt_ext, evt_code}, e);
          end
        end
      end
      @(negedge sysclk);
      g++;
    end
    evt_ready = 0;
    if (g >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s drain timeout left %0d", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_rel, evt_count,
         ctrl_byte, ctrl_valid, err_pulse, overflow,
         prefix_timeout} !== '0) begin
      errors++;
      $display("FAIL reset outputs nonzero cnt %0d v %b", evt_count,
               evt_valid);
    end
    @(negedge sysclk);
    rst_n = 1;
    @(negedge sysclk);
  endtask

  task automatic test_make;
    logic cv, ep, ev;
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 1, cv, ep, ev);
    checks++;
    if (ev !== 1'b1) begin
      errors++;
      $display("FAIL make latency got %b want 1", ev);
    end
    drain("make");
  endtask

  task automatic test_prefix;
    logic cv, ep, ev;
    exp_q.push_back({2'b11, 8'h75});
    send(8'hE0, 5, cv, ep, ev);
    send(8'hF0, 5, cv, ep, ev);
    send(8'h75, 5, cv, ep, ev);
    checks++;
    if (evt_count !== 1) begin
      errors++;
      $display("FAIL prefix count got %0d want 1", evt_count);
    end
    drain("e0f0");
    exp_q.push_back({2'b10, 8'h12});
    send(8'hF0, 1, cv, ep, ev);
    send(8'h12, 1, cv, ep, ev);
    exp_q.push_back({2'b01, 8'h6B});
    send(8'hE0, 1, cv, ep, ev);
    send(8'h6B, 1, cv, ep, ev);
    drain("single_prefix");
  endtask

  task automatic test_overflow;
    logic cv, ep, ev;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back({2'b00, 8'h20 + 8'(i)});
      send(8'h20 + 8'(i), 1, cv, ep, ev);
    end
    checks++;
    if (evt_count !== DEPTH) begin
      errors++;
      $display("FAIL ovf count got %0d want %0d", evt_count, DEPTH);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf flag got %b want 1", overflow);
    end
    ovf_clr = 1;
    @(negedge sysclk);
    ovf_clr = 0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b want 0", overflow);
    end
  endtask

  task automatic test_full_pop;
    logic [9:0] e;
    checks++;
    e = exp_q.pop_front();
    if ({evt_rel, evt_ext, evt_code} !== e) begin
      errors++;
      $display("FAIL fullpop head got %h want %h",
               {evt_rel, evt_ext, evt_code}, e);
    end
    exp_q.push_back({2'b00, 8'h2B});
    word = 8'h2B;
    done = 1;
    evt_ready = 1;
    @(negedge sysclk);
    evt_ready = 0;
    done = 0;
    checks++;
    if (evt_count !== DEPTH) begin
      errors++;
      $display("FAIL fullpop count got %0d want %0d", evt_count, DEPTH);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop ovf got %b want 0", overflow);
    end
    @(negedge sysclk);
    drain("wrap");
  endtask

  task automatic test_ctrl;
    logic cv, ep, ev;
    send(8'hF0, 1, cv, ep, ev);
    send(8'hAA, 1, cv, ep, ev);
    checks++;
    if (cv !== 1'b1 || ctrl_byte !== 8'hAA || ev !== 1'b0) begin
      errors++;
      $display("FAIL ctrl got v%b b%h e%b want 1 aa 0", cv, ctrl_byte,
               ev);
    end
    checks++;
    if (ctrl_valid !== 1'b0) begin
      errors++;
      $display("FAIL ctrl strobe width got %b want 0", ctrl_valid);
    end
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 1, cv, ep, ev);
    drain("after_ctrl");
    send(8'hFF, 1, cv, ep, ev);
    checks++;
    if (ep !== 1'b1 || cv !== 1'b0 || evt_count !== 0) begin
      errors++;
      $display("FAIL err got e%b c%b n%0d want 1 0 0", ep, cv,
               evt_count);
    end
    send(8'hFA, 1, cv, ep, ev);
    checks++;
    if (cv !== 1'b1 || ctrl_byte !== 8'hFA || ep !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_fa got v%b b%h want 1 fa", cv, ctrl_byte);
    end
  endtask

  task automatic test_reset_mid;
    logic cv, ep, ev;
    send(8'h33, 1, cv, ep, ev);
    send(8'hF0, 1, cv, ep, ev);
    rst_n = 0;
    @(negedge sysclk);
    checks++;
    if (evt_count !== 0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset count got %0d want 0", evt_count);
    end
    rst_n = 1;
    @(negedge sysclk);
    exp_q.push_back({2'b00, 8'h6B});
    send(8'h6B, 1, cv, ep, ev);
    drain("midreset");
  endtask

`ifdef SCAN_PREFIX_TIMEOUT_EN
  task automatic test_timeout;
    logic cv, ep, ev;
    int seen = 0;
    int at = -1;
    send(8'hE0, 1, cv, ep, ev);
    for (int i = 0; i < TMO + 10; i++) begin
      if (prefix_timeout) begin
        seen++;
        at = i;
      end
      @(negedge sysclk);
    end
    checks++;
    if (seen != 1 || at < TMO - 3) begin
      errors++;
      $display("FAIL timeout strobes got %0d at %0d want 1", seen, at);
    end
    exp_q.push_back({2'b00, 8'h6B});
    send(8'h6B, 1, cv, ep, ev);
    drain("timeout");
  endtask
`endif

  initial begin
    @(negedge sysclk);
    test_reset;
    test_make;
    test_prefix;
    test_overflow;
    test_full_pop;
    test_ctrl;
    test_reset_mid;
`ifdef SCAN_PREFIX_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
